typing_game_ctrl: RTL and testbench

Game-state and text-progress controller for the typing game. It latches a passage at game start, checks each decoded keystroke against the character under the cursor, and advances the cursor or counts an error. It also runs the countdown timer and the stop/start/pause/win/lose state machine. Its outputs drive the VGA display stage directly: text, Q and cur.

---
 rtl/typing_game_ctrl.sv | 133 +++++++++++++
 tb/tb_typing_game_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/typing_game_ctrl.sv
// Typing game controller: latches the passage, checks keystrokes against the cursor character,
// runs the one-second countdown and the stop/run/pause/win/lose state machine.
module typing_game_ctrl #(
   parameter int unsigned LEN        = 200,
   parameter int unsigned CLK_HZ     = 25000000,
   parameter int unsigned TIME_LIMIT = 60,
   parameter int unsigned MAX_ERR    = 10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               btn_start,
   input  logic               btn_pause,
   input  logic               key_valid,
   input  logic [5:0]         key_code,
   input  logic [6*LEN-1:0]   passage,
   output logic [6*LEN-1:0]   text,
   output logic [2:0]         Q,
   output logic [9:0]         cur,
   output logic [7:0]         time_left,
   output logic [3:0]         err_cnt
);

   localparam int unsigned    PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [9:0]     LEN_C     = 10'(LEN);
   localparam logic [4:0]     MAX_ERR_C = 5'(MAX_ERR);
   localparam logic [7:0]     TIME_INIT = 8'(TIME_LIMIT);

   typedef enum logic [2:0] {
      StStop  = 3'd0,
      StRun   = 3'd1,
      StPause = 3'd2,
      StWin   = 3'd3,
      StLose  = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [6*LEN-1:0]   text_q, text_d;
   logic [9:0]         cur_q, cur_d;
   logic [7:0]         time_q, time_d;
   logic [3:0]         err_q, err_d;
   logic [PW-1:0]      presc_q, presc_d;

   logic [5:0]         exp_char;
   logic               tick, hit, miss, win, lose_err, timeout;

   // Character under the cursor, selected as a mux over constant slices.
   always_comb begin
      exp_char = '0;
      for (int i = 0; i < LEN; i++) begin
         if (cur_q == 10'(i)) exp_char = text_q[6*i +: 6];
      end
   end

   always_comb begin
      tick     = (presc_q == PRESC_MAX);
      hit      = key_valid && (key_code == exp_char);
      miss     = key_valid && (key_code != exp_char);
      win      = hit && ((cur_q + 10'd1) == LEN_C);
      lose_err = miss && (({1'b0, err_q} + 5'd1) == MAX_ERR_C);
      timeout  = tick && (time_q == 8'd1);
   end

   always_comb begin
      state_d = state_q;
      text_d  = text_q;
      cur_d   = cur_q;
      time_d  = time_q;
      err_d   = err_q;
      presc_d = presc_q;
      case (state_q)
         StStop: begin
            if (btn_start) begin
               text_d  = passage;
               cur_d   = '0;
               err_d   = '0;
               time_d  = TIME_INIT;
               presc_d = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (hit) cur_d = cur_q + 10'd1;
            if (miss && (err_q != 4'hF)) err_d = err_q + 4'd1;
            if (win)                state_d = StWin;
            else if (lose_err)      state_d = StLose;
            else if (timeout)       state_d = StLose;
            else if (btn_pause)     state_d = StPause;
            // A pause that takes effect freezes the timer on that same edge.
            if (win || lose_err || timeout || !btn_pause) begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick) time_d = time_q - 8'd1;
            end
         end
         StPause: begin
            if (btn_start)      state_d = StStop;
            else if (btn_pause) state_d = StRun;
         end
         StWin, StLose: begin
            if (btn_start) begin
               state_d = StStop;
               cur_d   = '0;
            end
         end
         default: state_d = StStop;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StStop;
         text_q  <= '0;
         cur_q   <= '0;
         time_q  <= TIME_INIT;
         err_q   <= '0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         text_q  <= text_d;
         cur_q   <= cur_d;
         time_q  <= time_d;
         err_q   <= err_d;
         presc_q <= presc_d;
      end
   end

   assign text      = text_q;
   assign Q         = state_q;
   assign cur       = cur_q;
   assign time_left = time_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Bench for typing_game_ctrl: directed scenarios against fixed expectations, then random
// traffic against a cycle-level behavioural model of the game rules.
module tb_typing_game_ctrl;

   localparam int LEN        = 4;
   localparam int CLK_HZ     = 4;
   localparam int TIME_LIMIT = 3;
   localparam int MAX_ERR    = 2;

   logic               CLK = 1'b0;
   logic               RST, btn_start, btn_pause, key_valid;
   logic [5:0]         key_code;
   logic [6*LEN-1:0]   passage;
   logic [6*LEN-1:0]   text;
   logic [2:0]         Q;
   logic [9:0]         cur;
   logic [7:0]         time_left;
   logic [3:0]         err_cnt;

   int errors = 0;
   int checks = 0;

   // Model state, kept as plain integers
   int               m_state, m_cur, m_err, m_time, m_presc;
   int               m_text [LEN];
   logic [6*LEN-1:0] m_bits;

   localparam logic [6*LEN-1:0] PASS_A = {6'd8, 6'd7, 6'd6, 6'd5};

   typing_game_ctrl #(
      .LEN(LEN), .CLK_HZ(CLK_HZ), .TIME_LIMIT(TIME_LIMIT), .MAX_ERR(MAX_ERR)
   ) dut (
      .CLK(CLK), .RST(RST), .btn_start(btn_start), .btn_pause(btn_pause),
      .key_valid(key_valid), .key_code(key_code), .passage(passage), .text(text),
      .Q(Q), .cur(cur), .time_left(time_left), .err_cnt(err_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic model_step(input bit r, s, p, kv, input logic [5:0] kc);
      bit win, le, to, pausing;
      if (r) begin
         m_state = 0; m_cur = 0; m_err = 0; m_time = TIME_LIMIT; m_presc = 0; m_bits = '0;
         for (int i = 0; i < LEN; i++) m_text[i] = 0;
         return;
      end
      case (m_state)
         0: if (s) begin
            m_bits = passage;
            for (int i = 0; i < LEN; i++) m_text[i] = int'(passage[6*i +: 6]);
            m_cur = 0; m_err = 0; m_time = TIME_LIMIT; m_presc = 0; m_state = 1;
         end
         1: begin
            win = 0; le = 0; to = 0;
            if (kv) begin
               if (int'(kc) == m_text[m_cur]) begin
                  m_cur++;
                  win = (m_cur == LEN);
               end else begin
                  le = (m_err + 1 == MAX_ERR);
                  if (m_err < 15) m_err++;
               end
            end
            pausing = p && !win && !le && !(m_time == 1 && m_presc == CLK_HZ - 1);
            if (!pausing) begin
               m_presc++;
               if (m_presc == CLK_HZ) begin
                  m_presc = 0;
                  m_time--;
                  to = (m_time == 0);
               end
            end
            m_state = win ? 3 : le ? 4 : to ? 4 : p ? 2 : 1;
         end
         2: if (s) m_state = 0; else if (p) m_state = 1;
         default: if (s) begin m_state = 0; m_cur = 0; end
      endcase
   endtask

   task automatic cycle(input bit r, s, p, kv, input logic [5:0] kc);
      RST = r; btn_start = s; btn_pause = p; key_valid = kv; key_code = kc;
      @(posedge CLK);
      model_step(r, s, p, kv, kc);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 6'd0);
   endtask

   task automatic test_reset;
      cycle(1, 0, 0, 0, 6'd0);
      checks++; if (Q !== 3'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", Q); end
      checks++; if (cur !== 10'd0) begin errors++; $display("FAIL reset_cur: got %0d want 0", cur); end
      checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL reset_time: got %0d want 3", time_left); end
      checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
      checks++; if (text !== '0) begin errors++; $display("FAIL reset_text: got %h want 0", text); end
      idle(1);
      checks++; if (Q !== 3'd0) begin errors++; $display("FAIL stop_idle_q: got %0d want 0", Q); end
   endtask

   task automatic test_start;
      passage = PASS_A;
      cycle(0, 1, 0, 0, 6'd0);
      checks++; if (Q !== 3'd1) begin errors++; $display("FAIL start_q: got %0d want 1", Q); end
      checks++; if (cur !== 10'd0) begin errors++; $display("FAIL start_cur: got %0d want 0", cur); end
      checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL start_time: got %0d want 3", time_left); end
      checks++; if (text !== PASS_A) begin errors++; $display("FAIL start_text: got %h want %h", text, PASS_A); end
      passage = '1;
      cycle(0, 1, 0, 0, 6'd0);
      checks++; if (text !== PASS_A) begin errors++; $display("FAIL text_hold: got %h want %h", text, PASS_A); end
   endtask

   task automatic test_win;
      logic [5:0] keys [4];
      keys = '{6'd5, 6'd6, 6'd7, 6'd8};
      passage = PASS_A;
      cycle(0, 1, 0, 0, 6'd0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 1, keys[i]);
         checks++; if (cur !== 10'(i + 1)) begin errors++; $display("FAIL win_cur%0d: got %0d want %0d", i, cur, i + 1); end
         checks++; if (Q !== ((i == 3) ? 3'd3 : 3'd1)) begin errors++; $display("FAIL win_q%0d: got %0d want %0d", i, Q, (i == 3) ? 3 : 1); end
         if (i < 3) idle(1);
      end
      cycle(0, 0, 1, 1, 6'd5);
      checks++; if (cur !== 10'd4) begin errors++; $display("FAIL win_extra_cur: got %0d want 4", cur); end
      checks++; if (Q !== 3'd3) begin errors++; $display("FAIL win_extra_q: got %0d want 3", Q); end
      cycle(0, 1, 0, 0, 6'd0);
      checks++; if (Q !== 3'd0 || cur !== 10'd0) begin errors++; $display("FAIL win_exit: got q=%0d cur=%0d want q=0 cur=0", Q, cur); end
   endtask

   task automatic test_errors;
      cycle(0, 1, 0, 0, 6'd0);
      cycle(0, 0, 0, 1, 6'd9);
      checks++; if (err_cnt !== 4'd1 || Q !== 3'd1) begin errors++; $display("FAIL err1: got err=%0d q=%0d want err=1 q=1", err_cnt, Q); end
      cycle(0, 0, 0, 1, 6'd9);
      checks++; if (err_cnt !== 4'd2 || Q !== 3'd4 || cur !== 10'd0) begin errors++; $display("FAIL err2: got err=%0d q=%0d cur=%0d want 2 4 0", err_cnt, Q, cur); end
      cycle(0, 1, 0, 0, 6'd0);
      checks++; if (Q !== 3'd0) begin errors++; $display("FAIL lose_exit_q: got %0d want 0", Q); end
   endtask

   task automatic test_timeout;
      int exp_t;
      cycle(0, 1, 0, 0, 6'd0);
      for (int k = 1; k <= 12; k++) begin
         cycle(0, 0, 0, 0, 6'd0);
         exp_t = 3 - k / 4;
         checks++; if (time_left !== 8'(exp_t)) begin errors++; $display("FAIL timeout_t%0d: got %0d want %0d", k, time_left, exp_t); end
         checks++; if (Q !== ((k == 12) ? 3'd4 : 3'd1)) begin errors++; $display("FAIL timeout_q%0d: got %0d want %0d", k, Q, (k == 12) ? 4 : 1); end
      end
      cycle(0, 1, 0, 0, 6'd0);
   endtask

   task automatic test_pause;
      cycle(0, 1, 0, 0, 6'd0);
      idle(2);
      cycle(0, 0, 1, 0, 6'd0);
      checks++; if (Q !== 3'd2) begin errors++; $display("FAIL pause_q: got %0d want 2", Q); end
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, (i % 2) == 0, 6'd5);
      checks++; if (time_left !== 8'd3 || cur !== 10'd0 || Q !== 3'd2) begin
         errors++; $display("FAIL pause_frozen: got t=%0d cur=%0d q=%0d want 3 0 2", time_left, cur, Q); end
      cycle(0, 0, 1, 0, 6'd0);
      checks++; if (Q !== 3'd1) begin errors++; $display("FAIL resume_q: got %0d want 1", Q); end
      idle(1);
      checks++; if (time_left !== 8'd3) begin errors++; $display("FAIL resume_t1: got %0d want 3", time_left); end
      idle(1);
      checks++; if (time_left !== 8'd2) begin errors++; $display("FAIL resume_t2: got %0d want 2", time_left); end
      cycle(0, 0, 1, 0, 6'd0);
      cycle(0, 1, 1, 0, 6'd0);
      checks++; if (Q !== 3'd0) begin errors++; $display("FAIL pause_abort: got %0d want 0", Q); end
   endtask

   task automatic test_win_timeout;
      passage = PASS_A;
      cycle(0, 1, 0, 0, 6'd0);
      cycle(0, 0, 0, 1, 6'd5);
      cycle(0, 0, 0, 1, 6'd6);
      cycle(0, 0, 0, 1, 6'd7);
      idle(8);
      checks++; if (time_left !== 8'd1 || cur !== 10'd3) begin errors++; $display("FAIL wt_pre: got t=%0d cur=%0d want 1 3", time_left, cur); end
      cycle(0, 0, 0, 1, 6'd8);
      checks++; if (Q !== 3'd3 || time_left !== 8'd0 || cur !== 10'd4) begin
         errors++; $display("FAIL win_timeout: got q=%0d t=%0d cur=%0d want 3 0 4", Q, time_left, cur); end
      cycle(0, 1, 0, 0, 6'd0);
   endtask

   task automatic test_reset_mid;
      cycle(0, 1, 0, 0, 6'd0);
      cycle(0, 0, 0, 1, 6'd5);
      cycle(0, 0, 0, 1, 6'd1);
      idle(1);
      cycle(1, 0, 1, 1, 6'd6);
      checks++; if (Q !== 3'd0 || cur !== 10'd0 || err_cnt !== 4'd0 || time_left !== 8'd3 || text !== '0) begin
         errors++; $display("FAIL reset_mid: got q=%0d cur=%0d err=%0d t=%0d text=%h", Q, cur, err_cnt, time_left, text); end
   endtask

   task automatic test_random;
      bit r, s, p, kv;
      logic [5:0] kc;
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < LEN; i++) passage[6*i +: 6] = 6'($urandom_range(0, 3));
         r  = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 24) == 0);
         p  = ($urandom_range(0, 14) == 0);
         kv = ($urandom_range(0, 2) == 0);
         if (m_state == 1 && $urandom_range(0, 1) == 1) kc = 6'(m_text[m_cur]);
         else kc = 6'($urandom_range(0, 3));
         cycle(r, s, p, kv, kc);
         checks++; if (Q !== 3'(m_state)) begin errors++; $display("FAIL rnd_q@%0d: got %0d want %0d", n, Q, m_state); end
         checks++; if (cur !== 10'(m_cur)) begin errors++; $display("FAIL rnd_cur@%0d: got %0d want %0d", n, cur, m_cur); end
         checks++; if (time_left !== 8'(m_time)) begin errors++; $display("FAIL rnd_time@%0d: got %0d want %0d", n, time_left, m_time); end
         checks++; if (err_cnt !== 4'(m_err)) begin errors++; $display("FAIL rnd_err@%0d: got %0d want %0d", n, err_cnt, m_err); end
         checks++; if (text !== m_bits) begin errors++; $display("FAIL rnd_text@%0d: got %h want %h", n, text, m_bits); end
      end
   endtask

   initial begin
      RST = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; key_valid = 1'b0; key_code = '0;
      passage = PASS_A;
      test_reset;
      test_start;
      cycle(1, 0, 0, 0, 6'd0);
      test_win;
      test_errors;
      test_timeout;
      test_pause;
      test_win_timeout;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
